// File: rtl/div_seq.sv
// Sequential 32-bit signed divider (MIPS DIV semantics), one restoring step per cycle.
// Define DIV_SEQ_ZERO_TRAP_EN to short-circuit b == 0 into a 2-cycle div_zero completion.
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero,
    output logic [2:0]  dbg_state
);

`ifdef DIV_SEQ_ZERO_TRAP_EN
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, SIGN = 3'd3, ZERO = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, SIGN = 3'd3} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] sh;
    logic [31:0] rem_sh;
`ifdef DIV_SEQ_ZERO_TRAP_EN
    logic        dz_q, dz_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef DIV_SEQ_ZERO_TRAP_EN
        dz_d      = dz_q;
`endif
        // rem < |b| <= 2^31 keeps the shifted remainder inside 32 bits.
        sh        = {rem_q, quo_q} << 1;
        rem_sh    = sh[63:32];

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                quo_d     = a_q[31] ? -a_q : a_q;
                b_d       = b_q[31] ? -b_q : b_q;
                rem_d     = 32'd0;
                cnt_d     = 6'd0;
                neg_rem_d = a_q[31];
                neg_quo_d = a_q[31] ^ b_q[31];
`ifdef DIV_SEQ_ZERO_TRAP_EN
                state_d   = (b_q == 32'd0) ? ZERO : RUN;
`else
                state_d   = RUN;
`endif
            end
            RUN: begin
                if (rem_sh >= b_q) begin
                    rem_d = rem_sh - b_q;
                    quo_d = {sh[31:1], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = sh[31:0];
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
`ifdef DIV_SEQ_ZERO_TRAP_EN
                dz_d    = 1'b0;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
`ifdef DIV_SEQ_ZERO_TRAP_EN
            ZERO: begin
                dz_d    = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            cnt_q     <= 6'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
`ifdef DIV_SEQ_ZERO_TRAP_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef DIV_SEQ_ZERO_TRAP_EN
            dz_q      <= dz_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;
`ifdef DIV_SEQ_ZERO_TRAP_EN
    assign div_zero  = dz_q;
`else
    assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed MIPS DIV corner cases plus randomized operands against
// a plain-arithmetic reference model; honours DIV_SEQ_ZERO_TRAP_EN like the design.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
    logic [2:0]  dbg_state;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
    logic        exp_dz = 1'b0;
    int          exp_lat = 34;

    div_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: SV int division truncates toward zero, remainder follows the dividend.
    task automatic model(input logic [31:0] av, input logic [31:0] bv);
        int sa;
        int sb;
        sa = av;
        sb = bv;
        if (bv == 32'd0) begin
`ifdef DIV_SEQ_ZERO_TRAP_EN
            exp_lat = 2;
            exp_dz  = 1'b1;
`else
            exp_lat = 34;
            exp_dz  = 1'b0;
            exp_lo  = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
            exp_hi  = av;
`endif
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            exp_lat = 34;
            exp_dz  = 1'b0;
            exp_lo  = 32'h8000_0000;
            exp_hi  = 32'd0;
        end else begin
            exp_lat = 34;
            exp_dz  = 1'b0;
            exp_lo  = sa / sb;
            exp_hi  = sa % sb;
        end
    endtask

    // Called just before the accepting edge; counts edges to done and checks results.
    task automatic complete_op(input logic noise, input int pulse_at);
        int got;
        got = 0;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL accept_busy: busy=%b expected 1", busy);
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: done=%b expected 0 after accept", done);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == pulse_at) begin
                start = 1'b1;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                got = k;
                break;
            end
        end
        start = 1'b0;
        n_vec++;
        if (got != exp_lat) begin
            n_err++;
            $display("FAIL latency: done after %0d edges expected %0d", got, exp_lat);
        end
        n_vec++;
        if (lo !== exp_lo) begin
            n_err++;
            $display("FAIL lo: got %h expected %h", lo, exp_lo);
        end
        n_vec++;
        if (hi !== exp_hi) begin
            n_err++;
            $display("FAIL hi: got %h expected %h", hi, exp_hi);
        end
        n_vec++;
        if (div_zero !== exp_dz) begin
            n_err++;
            $display("FAIL div_zero: got %b expected %b", div_zero, exp_dz);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_at_done: got %b expected 0", busy);
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic noise);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        model(av, bv);
        complete_op(noise, 0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, div_zero, hi, lo, dbg_state} !== 70'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h st=%0d expected all 0",
                     busy, done, div_zero, hi, lo, dbg_state);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed;
        run_op(32'd7, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: done=%b expected 0", done);
        end
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(32'd5, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_err++;
            $display("FAIL hold: hi=%h lo=%h expected hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_ignore_start;
        int extra;
        extra = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        model(32'd100, 32'd7);
        complete_op(1'b0, 10);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL queued_start: %0d extra done pulses expected 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        run_op(32'd1000, 32'd33, 1'b0);
        run_op(32'hFFFF_FC18, 32'd33, 1'b0);
        run_op(32'd1000, 32'hFFFF_FFDF, 1'b0);
        run_op(32'd0, 32'd9, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] av;
        logic [31:0] bv;
        for (int i = 0; i < 30; i++) begin
            av = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       bv = $urandom;
                1:       bv = 32'($urandom_range(1, 20));
                2:       bv = 32'd0 - 32'($urandom_range(1, 20));
                3:       bv = 32'd0;
                default: bv = 32'hFFFF_FFFF;
            endcase
            run_op(av, bv, 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        dones = 0;
        run_op(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b dz=%b hi=%h lo=%h expected all 0",
                     busy, done, div_zero, hi, lo);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort_done: %0d done pulses expected 0", dones);
        end
        @(negedge clk);
        reset  = 1'b1;
        start  = 1'b1;
        a      = 32'd9;
        b      = 32'd3;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        exp_dz = 1'b0;
        model(32'd9, 32'd3);
        complete_op(1'b0, 0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_start;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
